// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns the level-valued button/switch word into sticky read-to-clear
// event flags with overflow, one shared auto-repeat engine and a maskable level interrupt.
module button_event_ctrl #(
  parameter logic [15:0] REPEAT_MASK   = 16'h001F,
  parameter logic [15:0] ANY_EDGE_MASK = 16'h07E0,
  parameter int unsigned REPEAT_DELAY  = 32'd50_000_000,
  parameter int unsigned REPEAT_RATE   = 32'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] buttonsIn,
  input  logic [15:0] irqMask,
  input  logic        readEn,
  output logic [15:0] readData,
  output logic        readValid,
  output logic        irqOut
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 32'd1);
  localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 32'd1);
  localparam logic [10:0] REP_MASK   = REPEAT_MASK[10:0];
  localparam logic [10:0] BOTH_MASK  = ANY_EDGE_MASK[10:0];

  function automatic logic [3:0] lowest_idx(input logic [10:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 10; i >= 0; i--) begin
      if (v[i]) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [10:0] prev_q, prev_d;
  logic [10:0] pending_q, pending_d;
  logic        ovf_q, ovf_d;
  logic [15:0] read_data_q, read_data_d;
  logic        read_valid_q, read_valid_d;
  logic        irq_q, irq_d;
  rep_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;

  logic [10:0] in_s, rise_s, fall_s, rep_rise_s, other_rise_s;
  logic [10:0] idx_onehot_s, rep_ev_s, new_ev_s, clr_s;
  logic [31:0] last_cnt_s;
  logic        held_s;
  logic        unused_s;

  assign unused_s = ^buttonsIn[15:11];

  // Edge detection and the shared auto-repeat engine's next state.
  always_comb begin
    in_s         = buttonsIn[10:0];
    prev_d       = in_s;
    rise_s       = in_s & ~prev_q;
    fall_s       = ~in_s & prev_q;
    rep_rise_s   = rise_s & REP_MASK;
    idx_onehot_s = 11'd1 << idx_q;
    other_rise_s = rep_rise_s & ~idx_onehot_s;
    held_s       = |(in_s & idx_onehot_s);
    last_cnt_s   = (state_q == DELAY) ? DELAY_LAST : RATE_LAST;
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    rep_ev_s     = 11'd0;
    case (state_q)
      IDLE: begin
        if (|rep_rise_s) begin
          idx_d   = lowest_idx(rep_rise_s);
          cnt_d   = 32'd0;
          state_d = DELAY;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY, REPEAT: begin
        // A fresh press on another repeatable bit steals the engine before anything else.
        if (|other_rise_s) begin
          idx_d   = lowest_idx(other_rise_s);
          cnt_d   = 32'd0;
          state_d = DELAY;
        end else if (!held_s) begin
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else if (cnt_q == last_cnt_s) begin
          rep_ev_s = idx_onehot_s;
          cnt_d    = 32'd0;
          state_d  = REPEAT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // Pending/overflow update, read snapshot and interrupt level.
  always_comb begin
    new_ev_s    = rise_s | (fall_s & BOTH_MASK) | rep_ev_s;
    clr_s       = readEn ? pending_q : 11'd0;
    pending_d   = (pending_q & ~clr_s) | new_ev_s;
    ovf_d       = (ovf_q & ~readEn) | (|(new_ev_s & pending_q & ~clr_s));
    read_valid_d = readEn;
    if (readEn) begin
      read_data_d = {ovf_q, 4'b0000, pending_q};
    end else begin
      read_data_d = read_data_q;
    end
    irq_d = |({ovf_d, 4'b0000, pending_d} & irqMask);
  end

  // State registers; reset tracks the live input so held levels raise no event.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= buttonsIn[10:0];
      pending_q    <= 11'd0;
      ovf_q        <= 1'b0;
      read_data_q  <= 16'd0;
      read_valid_q <= 1'b0;
      irq_q        <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      cnt_q        <= 32'd0;
    end else begin
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      irq_q        <= irq_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
    end
  end

  assign readData  = read_data_q;
  assign readValid = read_valid_q;
  assign irqOut    = irq_q;

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Event controller between the button/switch input word and the CPU I/O bus. It turns the level-valued 16-bit input word into sticky, read-to-clear event flags with an overflow indicator. It generates auto-repeat events for held push-buttons and drives a maskable interrupt request to the CPU. The CPU services it through a single-cycle read strobe.

## Interface
- `REPEAT_MASK`, 16'h001F: bits eligible for auto-repeat (push-buttons up/right/down/left/center).
- `ANY_EDGE_MASK`, 16'h07E0: bits that raise an event on both edges (slide switches). All other bits in 10:0 raise an event on the rising edge only.
- `REPEAT_DELAY`, 50_000_000: cycles from press to first repeat event. Legal range ≥2.
- `REPEAT_RATE`, 10_000_000: cycles between subsequent repeat events. Legal range ≥2.
- `clk` in 1: system clock. This is the block's only clock.
- `rst` in 1: reset, synchronous and active-high.
- `buttonsIn` in 16: debounced button/switch word. Bits 15:11 are ignored.
- `irqMask` in 16: per-bit interrupt enable. Bit 15 enables the overflow interrupt.
- `readEn` in 1: CPU read strobe, one cycle per read.
- `readData` out 16: snapshot of the event register. Bits 10:0 are events, 14:11 are zero, 15 is overflow.
- `readValid` out 1: qualifies `readData` for one cycle.
- `irqOut` out 1: interrupt request, registered.

## Operation
- `prevIn` register holds the previous `buttonsIn[10:0]`.
  - `rise = in & ~prev`; `fall = ~in & prev`.
  - `newEv = rise | (fall & ANY_EDGE_MASK) | repEv`.
- `pending[10:0]` update: `pending <= (pending & ~clr) | newEv`.
  - `clr` equals `pending` on a `readEn` cycle, otherwise zero.
  - A new event in the same cycle as a read survives. Set wins over clear.
- Overflow (`pending[15]`) sets when `newEv & pending & ~clr` is nonzero, i.e. an event hits a bit that is already pending and not being cleared. It clears on read unless it is set again in that same cycle.
- Read: on `readEn`, `readData <= {ovf, 4'b0, pending}` as sampled before the update, and `readValid <= 1`. When `readEn` is low, `readData` holds its value and `readValid <= 0`.
- IRQ: `irqOut <= |({ovf,4'b0,pending} & irqMask)`, computed from the post-update register values. It is level-sensitive: it drops when the read clears the causes or when the mask is changed.
- Auto-repeat engine. One engine is shared by all repeatable bits, with registers `state`, `idx[3:0]` and a 32-bit counter `cnt`.
  - IDLE:
    - Any `rise & REPEAT_MASK` → capture the lowest such index, set `cnt=0`, go to DELAY.
  - DELAY:
    - `buttonsIn[idx]==0` → IDLE, no event.
    - Else, `cnt==REPEAT_DELAY-1` → `repEv[idx]=1`, `cnt=0`, go to REPEAT.
    - Else → `cnt+1`.
  - REPEAT:
    - Release → IDLE.
    - Else, `cnt==REPEAT_RATE-1` → `repEv[idx]=1`, `cnt=0`.
    - Else → `cnt+1`.
  - Retarget: in DELAY or REPEAT, a new repeatable rising edge on a different bit captures that bit's index, sets `cnt=0` and goes to DELAY. Release checking has priority over retargeting only when both refer to `idx`.
  - `repEv` is combinational from the state and counter. It is at most one bit per cycle.
- Reset values:
  - `pending=0`, `ovf=0`, `readData=0`, `readValid=0`, `irqOut=0`.
  - `state=IDLE`, `cnt=0`, `idx=0`.
  - `prevIn <= buttonsIn[10:0]` during reset, so levels present at reset release produce no events.

## Timing
- An input change sampled at edge k sets `pending` at edge k; it is visible after k.
- `irqOut` asserts at edge k as well, because it is derived from the next-state value. This gives one-cycle input-to-IRQ latency.
- `readEn` sampled at edge r gives `readValid`/`readData` valid for the cycle after r. `irqOut` falls at edge r if no masked cause remains.
- With the button held from edge k, the first repeat event sets `pending` at edge k+REPEAT_DELAY. Later repeat events follow at intervals of exactly REPEAT_RATE.
- Back-to-back `readEn` strobes are legal. The second read returns only the events that arrived after the first.
- `rst` asserted mid-operation clears everything at the next edge and aborts any repeat in progress. No event is generated for bits that are held when `rst` falls.

## Test plan
Run with REPEAT_DELAY=8 and REPEAT_RATE=4.
- Reset with `buttonsIn=16'h0401`, release reset and hold the input for 20 cycles → `pending=0` and `irqOut=0` throughout.
- `irqMask=16'h0002`. Pulse bit 1 (right button) high for 3 cycles, then pulse `readEn` → `irqOut` rises one cycle after the press. `readData=16'h0002` with `readValid`. `irqOut` falls after the read.
- Toggle switch bit 6 high, then low, with no read in between → first `pending[6]=1`, then overflow. A read returns `16'h8040`.
- Hold bit 0 for 20 cycles after the rise → repeat events at +8, +12 and +16. Because there are no reads, the first repeat sets overflow.
- Press bit 2, then bit 3 three cycles later, while holding both → the engine retargets to bit 3. The first repeat on bit 3 comes 8 cycles after its rise; bit 2 receives no repeat events.
- Event and `readEn` in the same cycle on bit 4 → the read returns the old `pending`, `pending[4]` stays set, and no overflow is raised.
